// File: rtl/prog_mem_pkg.sv
// Shared constants for the program-memory loader: word/address geometry
// and the loader FSM state encoding.
package prog_mem_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    // Loader FSM state encoding (PM_STATE)
    localparam logic [2:0] PM_RUN        = 3'd0;
    localparam logic [2:0] PM_LD_IDLE    = 3'd1;
    localparam logic [2:0] PM_LD_DEBOUNCE = 3'd2;
    localparam logic [2:0] PM_LD_WRITE   = 3'd3;
    localparam logic [2:0] PM_LD_RELEASE = 3'd4;

endpackage

// File: rtl/prog_mem_debounce.sv
// Push-button qualifier: two-flop synchronizer plus a stable-sample counter.
// The owning FSM picks the phase (press or release) and when the counter
// runs; this block reports when the button has been stable long enough.
module prog_mem_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    input  logic clr_i,
    input  logic run_i,
    input  logic release_i,
    output logic btn_s_o,
    output logic press_ok_o,
    output logic release_ok_o
);

    logic [1:0]  sync_q;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] cnt_inc;

    assign btn_s_o = sync_q[1];
    assign cnt_inc = cnt_q + 16'd1;

    // A press is accepted on the sample that brings the counter to
    // DEBOUNCE_CYCLES-1 (the idle sample that started debounce counts too).
    assign press_ok_o   = run_i & ~release_i & btn_s_o & (cnt_inc >= (DEBOUNCE_CYCLES - 16'd1));
    // A release needs DEBOUNCE_CYCLES consecutive low samples.
    assign release_ok_o = run_i & release_i & ~btn_s_o & (cnt_inc >= DEBOUNCE_CYCLES);

    // Two-flop synchronizer for the asynchronous button
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b00;
        else        sync_q <= {sync_q[0], btn_i};
    end

    // Counter counts samples at the wanted level and restarts on any other level
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 16'd0;
        end else if (run_i) begin
            if (btn_s_o ^ release_i) cnt_d = cnt_inc;
            else                     cnt_d = 16'd0;
        end
    end

    // Stable-sample counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= 16'd0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/prog_mem.sv
// 16 x 8 program memory with a switch/push-button loader. The CPU reads
// combinationally at any time; while load mode is active the CPU is held
// and each debounced button press stores one byte at the next address.
module prog_mem
    import prog_mem_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    input  logic              load_en,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_btn,
    output logic [ADDR_W-1:0] load_addr,
    output logic              cpu_hold,
    output logic              loaded,
    output logic [2:0]        dbg_state_o
);

    logic [1:0]        en_sync_q;
    logic              load_en_s;
    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic dbc_clr, dbc_run, dbc_release;
    logic btn_s, press_ok, release_ok;

    assign load_en_s   = en_sync_q[1];
    assign mem_data    = mem_q[mem_addr];
    assign load_addr   = addr_q;
    assign loaded      = (state_q == PM_LD_WRITE);
    assign cpu_hold    = (state_q != PM_RUN) | load_en_s;
    assign dbg_state_o = state_q;

    prog_mem_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_i        (load_btn),
        .clr_i        (dbc_clr),
        .run_i        (dbc_run),
        .release_i    (dbc_release),
        .btn_s_o      (btn_s),
        .press_ok_o   (press_ok),
        .release_ok_o (release_ok)
    );

    // Two-flop synchronizer for the load-mode switch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) en_sync_q <= 2'b00;
        else        en_sync_q <= {en_sync_q[0], load_en};
    end

    // Loader FSM next state; dropping load_en leaves any LD_* state,
    // but a write already in LD_WRITE completes this cycle
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        dbc_clr     = 1'b1;
        dbc_run     = 1'b0;
        dbc_release = 1'b0;
        case (state_q)
            PM_RUN: begin
                if (load_en_s) begin
                    state_d = PM_LD_IDLE;
                    addr_d  = '0;
                end
            end
            PM_LD_IDLE: begin
                if (!load_en_s)  state_d = PM_RUN;
                else if (btn_s)  state_d = PM_LD_DEBOUNCE;
            end
            PM_LD_DEBOUNCE: begin
                dbc_clr = 1'b0;
                dbc_run = 1'b1;
                if (!load_en_s)    state_d = PM_RUN;
                else if (!btn_s)   state_d = PM_LD_IDLE;
                else if (press_ok) state_d = PM_LD_WRITE;
            end
            PM_LD_WRITE: begin
                addr_d  = addr_q + 1'b1;
                state_d = load_en_s ? PM_LD_RELEASE : PM_RUN;
            end
            PM_LD_RELEASE: begin
                dbc_clr     = 1'b0;
                dbc_run     = 1'b1;
                dbc_release = 1'b1;
                if (!load_en_s)      state_d = PM_RUN;
                else if (release_ok) state_d = PM_LD_IDLE;
            end
            default: state_d = PM_RUN;
        endcase
    end

    // FSM state and write-address registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PM_RUN;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // Storage array: cleared by reset, written once per LD_WRITE cycle;
    // switches are held steady by the operator so load_data is used directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (state_q == PM_LD_WRITE) begin
            mem_q[addr_q] <= load_data;
        end
    end

endmodule
